// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg -- shared types and default constants for the register-file dump block.
//   state_t      : dump FSM state encoding (IDLE, READ, SEND, DONE)
//   NREG_DEF     : default number of registers scanned per dump
//   AW_DEF       : default register address width
//   DW_DEF       : default register data width
package rf_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned DW_DEF   = 32;

endpackage

// File: rtl/rf_dump.sv
// rf_dump -- walks a register file from index 0 to NREG-1 on request and
// streams each register value out over a valid/ready interface.
//
// Optional feature: define RF_DUMP_CHECKSUM_EN to keep a running XOR of every
// transferred word; otherwise checksum is tied to zero and no register exists.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rstn       in   asynchronous active-low reset
//   start      in   dump request, sampled only while idle
//   busy       out  dump in progress (READ, SEND, DONE)
//   rf_addr    out  register-file read address (index counter)
//   rf_data    in   register-file read data, combinational from rf_addr
//   dump_valid out  stream word valid
//   dump_ready in   stream sink ready
//   dump_idx   out  register index of the current stream word
//   dump_data  out  register value of the current stream word
//   done       out  one-cycle pulse after the last word transfers
//   checksum   out  XOR of all words of the last dump (zero when disabled)
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          done,
    output logic [DW-1:0] checksum
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_idx;
    logic          r_valid;
    logic [AW-1:0] r_didx;
    logic [DW-1:0] r_data;

    logic          w_start_acc;
    logic          w_xfer;
    logic          w_last;

    // Start only counts when idle; a transfer only happens on a presented word.
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_xfer      = (r_state == SEND) && r_valid && dump_ready;
    assign w_last      = (r_idx == AW'(NREG - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = READ;
            end
            READ: w_next = SEND;
            SEND: begin
                if (w_xfer) w_next = w_last ? DONE : READ;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Index counter: cleared on accepted start, advanced on each non-final transfer,
    // so it saturates at NREG-1 within a dump.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
        end else if (w_start_acc) begin
            r_idx <= '0;
        end else if (w_xfer && !w_last) begin
            r_idx <= r_idx + AW'(1);
        end
    end

    // Stream word registers: loaded in READ, held through SEND until accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_didx  <= '0;
            r_data  <= '0;
        end else if (r_state == READ) begin
            r_valid <= 1'b1;
            r_didx  <= r_idx;
            r_data  <= rf_data;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

`ifdef RF_DUMP_CHECKSUM_EN
    logic [DW-1:0] r_ck;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ck <= '0;
        end else if (w_start_acc) begin
            r_ck <= '0;
        end else if (w_xfer) begin
            r_ck <= r_ck ^ r_data;
        end
    end

    assign checksum = r_ck;
`else
    assign checksum = '0;
`endif

    assign rf_addr    = r_idx;
    assign dump_valid = r_valid;
    assign dump_idx   = r_didx;
    assign dump_data  = r_data;

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump -- directed self-checking bench for rf_dump (default parameters).
// Works with or without RF_DUMP_CHECKSUM_EN; expected checksum follows the macro.
module tb_rf_dump;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          busy;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] rf [0:NREG-1];

    int checks;
    int errors;

    rf_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read.
    always_comb rf_data = rf[rf_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_ck();
        logic [DW-1:0] x;
        x = '0;
`ifdef RF_DUMP_CHECKSUM_EN
        for (int i = 0; i < NREG; i++) x = x ^ rf[i];
`endif
        return x;
    endfunction

    // One complete dump with dump_ready normally high. Optionally stalls 5 cycles
    // on word stall_idx and pulses start again while word restart_idx is presented.
    task automatic do_dump(input int stall_idx, input int restart_idx,
                           input int exp_done_cyc, input logic [DW-1:0] exp_ck);
        int            cyc;
        int            nxt;
        int            ndone;
        int            done_cyc;
        logic [AW-1:0] sidx;
        logic [DW-1:0] sdata;
        nxt = 0; ndone = 0; done_cyc = -1;
        dump_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("valid_in_read", {63'd0, dump_valid}, 64'd0);
        while (cyc < 400) begin
            if (dump_valid) begin
                check("word_idx", {59'd0, dump_idx}, 64'(nxt));
                check("word_data", {32'd0, dump_data}, {32'd0, rf[nxt % NREG]});
                if (int'(dump_idx) == stall_idx) begin
                    sidx  = dump_idx;
                    sdata = dump_data;
                    dump_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        tick(); cyc++;
                        check("stall_valid", {63'd0, dump_valid}, 64'd1);
                        check("stall_idx", {59'd0, dump_idx}, {59'd0, sidx});
                        check("stall_data", {32'd0, dump_data}, {32'd0, sdata});
                    end
                    dump_ready = 1'b1;
                end
                if (int'(dump_idx) == restart_idx) start = 1'b1;
                nxt++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                break;
            end
            tick(); cyc++;
            start = 1'b0;
        end
        check("done_seen", 64'(ndone), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(exp_done_cyc));
        check("word_count", 64'(nxt), 64'(NREG));
        check("busy_at_done", {63'd0, busy}, 64'd1);
        check("checksum_at_done", {32'd0, checksum}, {32'd0, exp_ck});
        tick();
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("checksum_stable", {32'd0, checksum}, {32'd0, exp_ck});
        tick();
        check("idle_no_done", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int            cyc;
        logic [DW-1:0] ck;
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < NREG; i++) rf[i] = DW'(i) * 32'h1111_1111;

        // Reset state
        tick(); tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, dump_valid}, 64'd0);
        check("rst_idx", {59'd0, dump_idx}, 64'd0);
        check("rst_data", {32'd0, dump_data}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ck", {32'd0, checksum}, 64'd0);
        check("rst_addr", {59'd0, rf_addr}, 64'd0);
        rstn = 1'b1;
        tick();
        // Idle with start low stays idle; ready without valid does nothing.
        dump_ready = 1'b1;
        tick(); tick();
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_valid", {63'd0, dump_valid}, 64'd0);

        // Full dump, ready always high
        do_dump(-1, -1, 64, model_ck());
        // Backpressure on word 3
        do_dump(3, -1, 69, model_ck());
        // Start pulsed again while word 10 is presented
        do_dump(-1, 10, 64, model_ck());

        // Reset in the middle of a dump
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(dump_valid && dump_idx == 5'd17) && cyc < 200) begin
            tick(); cyc++;
        end
        check("mid_reach_17", {59'd0, dump_idx}, 64'd17);
        #2 rstn = 1'b0;
        #1;
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_valid", {63'd0, dump_valid}, 64'd0);
        check("mid_idx", {59'd0, dump_idx}, 64'd0);
        check("mid_data", {32'd0, dump_data}, 64'd0);
        check("mid_done", {63'd0, done}, 64'd0);
        check("mid_ck", {32'd0, checksum}, 64'd0);
        check("mid_addr", {59'd0, rf_addr}, 64'd0);
        tick(); tick();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_busy", {63'd0, busy}, 64'd0);
            check("post_rst_done", {63'd0, done}, 64'd0);
            check("post_rst_valid", {63'd0, dump_valid}, 64'd0);
        end
        do_dump(-1, -1, 64, model_ck());

        // Checksum pattern
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        rf[1] = 32'hA5A5_A5A5;
        rf[2] = 32'h0F0F_0F0F;
`ifdef RF_DUMP_CHECKSUM_EN
        ck = 32'hAAAA_AAAA;
`else
        ck = 32'h0000_0000;
`endif
        do_dump(-1, -1, 64, ck);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_dump.md
RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 Parameter NREG, default 32, number of registers scanned per dump.
REQ-002 Parameter AW, default 5, register address width; SHALL satisfy 2**AW >= NREG.
REQ-003 Parameter DW, default 32, register data width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  dump request; sampled only in IDLE.
REQ-007 busy  output  1  high in READ, SEND and DONE.
REQ-008 rf_addr  output  AW  register-file read-port address, driven from the internal index counter.
REQ-009 rf_data  input  DW  register-file read data, combinational from rf_addr in the same cycle.
REQ-010 dump_valid  output  1  stream word valid.
REQ-011 dump_ready  input  1  stream sink ready.
REQ-012 dump_idx  output  AW  register index of the current stream word.
REQ-013 dump_data  output  DW  register value of the current stream word.
REQ-014 done  output  1  one-cycle pulse after the last word transfers.
REQ-015 checksum  output  DW  XOR of all words in the last dump (see REQ-028).

Function
REQ-016 FSM states: IDLE, READ, SEND, DONE.
REQ-017 IDLE with start=1: index cleared to 0; next state READ.
REQ-018 IDLE with start=0: FSM stays in IDLE.
REQ-019 READ: rf_data captured into dump_data; dump_idx set to index; dump_valid set; next state SEND.
REQ-020 SEND: dump_valid, dump_idx and dump_data held stable while dump_ready=0.
REQ-021 SEND with dump_ready=1 and index<NREG-1: dump_valid cleared; index incremented; next state READ.
REQ-022 SEND with dump_ready=1 and index=NREG-1: dump_valid cleared; next state DONE.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-024 Latency: dump_valid first rises 2 cycles after the start cycle; throughput is at most 1 word per 2 cycles.
REQ-025 start is ignored while busy=1; no restart and no queueing.
REQ-026 Index never exceeds NREG-1; no wrap-around within a dump.
REQ-027 dump_ready=1 while dump_valid=0 has no effect.

Reset
REQ-028 rstn low asynchronously forces: state IDLE, index 0, dump_valid 0, dump_idx 0, dump_data 0, done 0, checksum 0; busy is therefore 0.
REQ-029 Reset mid-dump aborts the dump; no done pulse is generated; after release the block waits for a new start.

Configuration
REQ-030 Macro RF_DUMP_CHECKSUM_EN defined: the checksum register is cleared on an accepted start, XORed with dump_data on each transfer (dump_valid and dump_ready both 1), and stable from the done cycle until the next start.
REQ-031 Macro RF_DUMP_CHECKSUM_EN undefined: checksum is tied to 0 and no checksum register is instantiated.

Structure
REQ-032 Package rf_dump_pkg holds the FSM state typedef (IDLE, READ, SEND, DONE) and the default constants NREG=32, AW=5, DW=32.
REQ-033 Single module; no sub-module; the index counter and FSM are both inline.

Verification
REQ-034 Regfile preloaded with rf[i]=i*0x11111111 (rf[0]=0); pulse start; dump_ready held at 1 -> 32 words, idx 0..31 in order, data matches, done pulses 64 cycles after start, busy falls after done.
REQ-035 dump_ready held at 0 for 5 cycles at idx=3 -> dump_valid, dump_idx=3 and dump_data stay constant throughout; transfer occurs on the cycle ready rises.
REQ-036 start pulsed again at idx=10 -> ignored; dump completes with exactly 32 words and one done pulse.
REQ-037 rstn asserted at idx=17 -> all outputs 0 immediately; no done pulse; a new start afterwards dumps from idx 0.
REQ-038 RF_DUMP_CHECKSUM_EN defined, rf[1]=0xA5A5A5A5, rf[2]=0x0F0F0F0F, all other registers 0 -> checksum=0xAAAAAAAA at done; with the macro undefined -> checksum=0.
